cmd_dispatch: RTL and testbench



---
 rtl/cmd_pkg.sv | 40 ++++
 rtl/cmd_dispatch_if.sv | 23 ++
 rtl/cmd_regfile.sv | 79 +++++++
 rtl/cmd_dispatch.sv | 158 +++++++++++++++
 tb/tb_cmd_dispatch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the oscilloscope command dispatcher: opcodes, readback
// addresses, default response words and the FSM state encoding.
package cmd_pkg;

  localparam logic [15:0] ACK_DEFAULT      = 16'h00A5;
  localparam logic [15:0] NAK_DEFAULT      = 16'h00EE;
  localparam logic [7:0]  TRIG_MIN_DEFAULT = 8'd46;
  localparam logic [7:0]  TRIG_MAX_DEFAULT = 8'd201;

  localparam logic [3:0] OP_DUMP     = 4'h1;
  localparam logic [3:0] OP_GAIN     = 4'h2;
  localparam logic [3:0] OP_TRIG_LVL = 4'h3;
  localparam logic [3:0] OP_TRIG_POS = 4'h4;
  localparam logic [3:0] OP_DEC      = 4'h5;
  localparam logic [3:0] OP_TRIG_CFG = 4'h6;
  localparam logic [3:0] OP_READ     = 4'h7;

  localparam logic [3:0] RA_TRIG_CFG = 4'd0;
  localparam logic [3:0] RA_TRIG_LVL = 4'd1;
  localparam logic [3:0] RA_TRIG_POS = 4'd2;
  localparam logic [3:0] RA_DEC      = 4'd3;
  localparam logic [3:0] RA_GAIN0    = 4'd4;
  localparam logic [3:0] RA_GAIN1    = 4'd5;
  localparam logic [3:0] RA_GAIN2    = 4'd6;
  localparam logic [3:0] RA_DROP     = 4'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    WAIT_DUMP = 2'd2,
    RESP      = 2'd3
  } state_t;

  function automatic logic in_range(input logic [7:0] val,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command/response and dump handshake bundle between the SPI slave, the dump
// engine (master side) and the dispatcher (slave side).
interface cmd_dispatch_if;

  logic [15:0] cmd_rcvd;
  logic        cmd_rdy;
  logic        dump_done;
  logic [15:0] tx_data;
  logic        wrt;
  logic        dump_req;
  logic [1:0]  dump_ch;

  modport master (
    output cmd_rcvd, cmd_rdy, dump_done,
    input  tx_data, wrt, dump_req, dump_ch
  );

  modport slave (
    input  cmd_rcvd, cmd_rdy, dump_done,
    output tx_data, wrt, dump_req, dump_ch
  );

endinterface

// File: rtl/cmd_regfile.sv
// Capture configuration registers, the sticky drop flag and the readback mux.
// Legality is decided by the FSM; this block writes whatever it is told to.
module cmd_regfile
  import cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_op,
  input  logic [1:0]  wr_ch,
  input  logic [8:0]  wr_data,
  input  logic [3:0]  rd_addr,
  input  logic        set_drop,
  input  logic        clr_drop,
  output logic [15:0] rd_data,
  output logic [5:0]  trig_cfg,
  output logic [7:0]  trig_lvl,
  output logic [8:0]  trig_pos,
  output logic [3:0]  decimator,
  output logic [2:0]  gain0,
  output logic [2:0]  gain1,
  output logic [2:0]  gain2,
  output logic        cmd_drop
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_cfg  <= 6'h00;
      trig_lvl  <= 8'h80;
      trig_pos  <= 9'h100;
      decimator <= 4'h0;
      gain0     <= 3'h2;
      gain1     <= 3'h2;
      gain2     <= 3'h2;
    end else if (wr_en) begin
      case (wr_op)
        OP_GAIN: begin
          case (wr_ch)
            2'd0:    gain0 <= wr_data[2:0];
            2'd1:    gain1 <= wr_data[2:0];
            2'd2:    gain2 <= wr_data[2:0];
            default: ;
          endcase
        end
        OP_TRIG_LVL: trig_lvl  <= wr_data[7:0];
        OP_TRIG_POS: trig_pos  <= wr_data;
        OP_DEC:      decimator <= wr_data[3:0];
        OP_TRIG_CFG: trig_cfg  <= wr_data[5:0];
        default: ;
      endcase
    end
  end

  // A collision seen in the same cycle as a read-clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cmd_drop <= 1'b0;
    else if (set_drop)
      cmd_drop <= 1'b1;
    else if (clr_drop)
      cmd_drop <= 1'b0;
  end

  always_comb begin
    rd_data = 16'h0000;
    case (rd_addr)
      RA_TRIG_CFG: rd_data = {10'b0, trig_cfg};
      RA_TRIG_LVL: rd_data = {8'b0, trig_lvl};
      RA_TRIG_POS: rd_data = {7'b0, trig_pos};
      RA_DEC:      rd_data = {12'b0, decimator};
      RA_GAIN0:    rd_data = {13'b0, gain0};
      RA_GAIN1:    rd_data = {13'b0, gain1};
      RA_GAIN2:    rd_data = {13'b0, gain2};
      RA_DROP:     rd_data = {15'b0, cmd_drop};
      default:     rd_data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Decodes 16-bit SPI command words, updates the capture configuration or starts
// a channel dump, and returns one ACK/NAK/readback word per accepted command.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter logic [15:0] ACK_VAL  = ACK_DEFAULT,
  parameter logic [15:0] NAK_VAL  = NAK_DEFAULT,
  parameter logic [7:0]  TRIG_MIN = TRIG_MIN_DEFAULT,
  parameter logic [7:0]  TRIG_MAX = TRIG_MAX_DEFAULT
)(
  input  logic           clk,
  input  logic           rst_n,
  cmd_dispatch_if.slave  bus,
  output logic [5:0]     trig_cfg,
  output logic [7:0]     trig_lvl,
  output logic [8:0]     trig_pos,
  output logic [3:0]     decimator,
  output logic [2:0]     gain0,
  output logic [2:0]     gain1,
  output logic [2:0]     gain2,
  output logic           cmd_drop
);

  state_t      state, state_nxt;
  logic        rdy_q;
  logic        rise;
  logic [15:0] cmd_q;
  logic [15:0] rsp_q, rsp_nxt;
  logic [1:0]  dump_ch_q;
  logic        done_q;
  logic        wr_en;
  logic        clr_drop;
  logic        set_drop;
  logic        dump_go;
  logic [15:0] rd_data;

  logic [3:0]  opcode;
  logic [3:0]  addr;
  logic [1:0]  chan;
  logic [7:0]  data;

  assign opcode   = cmd_q[15:12];
  assign addr     = cmd_q[11:8];
  assign chan     = cmd_q[9:8];
  assign data     = cmd_q[7:0];

  assign rise     = bus.cmd_rdy & ~rdy_q;
  assign set_drop = rise && (state != IDLE);

  // dump_done is only honoured while waiting; the extra register stage keeps a
  // pulse that lands in DECODE from being counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      rsp_q     <= 16'h0000;
      dump_ch_q <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_q  <= bus.cmd_rdy;
      rsp_q  <= rsp_nxt;
      done_q <= bus.dump_done && (state == WAIT_DUMP);
      if (state == IDLE && rise)
        cmd_q <= bus.cmd_rcvd;
      if (dump_go)
        dump_ch_q <= chan;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_nxt   = rsp_q;
    wr_en     = 1'b0;
    clr_drop  = 1'b0;
    dump_go   = 1'b0;
    case (state)
      IDLE: begin
        if (rise)
          state_nxt = DECODE;
      end
      DECODE: begin
        state_nxt = RESP;
        rsp_nxt   = NAK_VAL;
        case (opcode)
          OP_DUMP: begin
            if (chan != 2'd3) begin
              dump_go   = 1'b1;
              rsp_nxt   = rsp_q;
              state_nxt = WAIT_DUMP;
            end
          end
          OP_GAIN: begin
            if (chan != 2'd3) begin
              wr_en   = 1'b1;
              rsp_nxt = ACK_VAL;
            end
          end
          OP_TRIG_LVL: begin
            if (in_range(data, TRIG_MIN, TRIG_MAX)) begin
              wr_en   = 1'b1;
              rsp_nxt = ACK_VAL;
            end
          end
          OP_TRIG_POS, OP_DEC, OP_TRIG_CFG: begin
            wr_en   = 1'b1;
            rsp_nxt = ACK_VAL;
          end
          OP_READ: begin
            if (addr <= RA_DROP) begin
              rsp_nxt  = rd_data;
              clr_drop = (addr == RA_DROP);
            end
          end
          default: ;
        endcase
      end
      WAIT_DUMP: begin
        if (done_q) begin
          rsp_nxt   = ACK_VAL;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.wrt      = (state == RESP);
  assign bus.tx_data  = rsp_q;
  assign bus.dump_req = dump_go;
  assign bus.dump_ch  = dump_go ? chan : dump_ch_q;

  cmd_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_op     (opcode),
    .wr_ch     (chan),
    .wr_data   (cmd_q[8:0]),
    .rd_addr   (addr),
    .set_drop  (set_drop),
    .clr_drop  (clr_drop),
    .rd_data   (rd_data),
    .trig_cfg  (trig_cfg),
    .trig_lvl  (trig_lvl),
    .trig_pos  (trig_pos),
    .decimator (decimator),
    .gain0     (gain0),
    .gain1     (gain1),
    .gain2     (gain2),
    .cmd_drop  (cmd_drop)
  );

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch: hand-computed responses, latencies, dump
// handshake, busy collisions and asynchronous reset during a dump.
module tb_cmd_dispatch;

  localparam logic [15:0] ACK = 16'h00A5;
  localparam logic [15:0] NAK = 16'h00EE;

  logic       clk;
  logic       rst_n;
  logic [5:0] trig_cfg;
  logic [7:0] trig_lvl;
  logic [8:0] trig_pos;
  logic [3:0] decimator;
  logic [2:0] gain0, gain1, gain2;
  logic       cmd_drop;

  int checks;
  int errors;
  int wrt_cnt;
  int dump_cnt;
  int wrt_base;
  int dump_base;

  cmd_dispatch_if bus ();

  cmd_dispatch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .trig_cfg  (trig_cfg),
    .trig_lvl  (trig_lvl),
    .trig_pos  (trig_pos),
    .decimator (decimator),
    .gain0     (gain0),
    .gain1     (gain1),
    .gain2     (gain2),
    .cmd_drop  (cmd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wrt)      wrt_cnt++;
    if (bus.dump_req) dump_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Sends one command, expects wrt exactly two cycles after the cmd_rdy edge,
  // a single-cycle strobe and the given response word.
  task automatic applyStimulus(input logic [15:0] cmd, input logic [15:0] exp, input string tag);
    int lat;
    lat = -1;
    bus.cmd_rcvd = cmd;
    bus.cmd_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.wrt) begin
        lat = i;
        break;
      end
      tick();
    end
    checkOutput({tag, "_lat"}, lat, 2);
    checkOutput({tag, "_rsp"}, bus.tx_data, exp);
    tick();
    checkOutput({tag, "_wrt1"}, bus.wrt, 1'b0);
    checkOutput({tag, "_hold"}, bus.tx_data, exp);
    bus.cmd_rdy = 1'b0;
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    wrt_cnt       = 0;
    dump_cnt      = 0;
    rst_n         = 1'b0;
    bus.cmd_rcvd  = 16'h0000;
    bus.cmd_rdy   = 1'b0;
    bus.dump_done = 1'b0;
    repeat (3) tick();

    checkOutput("rst_tx", bus.tx_data, 16'h0000);
    checkOutput("rst_wrt", bus.wrt, 1'b0);
    checkOutput("rst_lvl", trig_lvl, 8'h80);
    checkOutput("rst_pos", trig_pos, 9'h100);
    checkOutput("rst_gain1", gain1, 3'h2);
    checkOutput("rst_drop", cmd_drop, 1'b0);
    rst_n = 1'b1;
    tick();

    applyStimulus(16'h7100, 16'h0080, "rd_lvl_rst");
    applyStimulus(16'h7400, 16'h0002, "rd_gain0_rst");

    // Trigger level window, including both boundaries and just outside them.
    applyStimulus(16'h3064, ACK, "lvl_64");
    checkOutput("lvl_64_reg", trig_lvl, 8'h64);
    applyStimulus(16'h302D, NAK, "lvl_45");
    checkOutput("lvl_45_reg", trig_lvl, 8'h64);
    applyStimulus(16'h302E, ACK, "lvl_46");
    checkOutput("lvl_46_reg", trig_lvl, 8'h2E);
    applyStimulus(16'h30C9, ACK, "lvl_201");
    checkOutput("lvl_201_reg", trig_lvl, 8'hC9);
    applyStimulus(16'h30CA, NAK, "lvl_202");
    checkOutput("lvl_202_reg", trig_lvl, 8'hC9);

    applyStimulus(16'h2005, ACK, "gain0_w");
    applyStimulus(16'h2103, ACK, "gain1_w");
    applyStimulus(16'h2307, NAK, "gain3_w");
    applyStimulus(16'h4123, ACK, "pos_w");
    applyStimulus(16'h5007, ACK, "dec_w");
    applyStimulus(16'h603F, ACK, "cfg_w");
    applyStimulus(16'h7000, 16'h003F, "rd_cfg");
    applyStimulus(16'h7200, 16'h0123, "rd_pos");
    applyStimulus(16'h7300, 16'h0007, "rd_dec");
    applyStimulus(16'h7400, 16'h0005, "rd_gain0");
    applyStimulus(16'h7500, 16'h0003, "rd_gain1");
    applyStimulus(16'h7600, 16'h0002, "rd_gain2");
    checkOutput("gain0_reg", gain0, 3'h5);
    checkOutput("gain2_reg", gain2, 3'h2);

    // Legal dump on channel 2 with a colliding command while waiting.
    wrt_base     = wrt_cnt;
    dump_base    = dump_cnt;
    bus.cmd_rcvd = 16'h1200;
    bus.cmd_rdy  = 1'b1;
    tick();
    checkOutput("dump_req_hi", bus.dump_req, 1'b1);
    checkOutput("dump_ch_req", bus.dump_ch, 2'd2);
    tick();
    checkOutput("dump_req_lo", bus.dump_req, 1'b0);
    bus.cmd_rdy = 1'b0;
    repeat (5) tick();
    bus.cmd_rcvd = 16'h7100;
    bus.cmd_rdy  = 1'b1;
    repeat (3) tick();
    bus.cmd_rdy = 1'b0;
    repeat (10) tick();
    checkOutput("busy_drop", cmd_drop, 1'b1);
    checkOutput("dump_no_wrt", wrt_cnt - wrt_base, 0);
    checkOutput("dump_pulses", dump_cnt - dump_base, 1);
    checkOutput("dump_ch_held", bus.dump_ch, 2'd2);
    bus.dump_done = 1'b1;
    tick();
    bus.dump_done = 1'b0;
    checkOutput("done_wrt_c1", bus.wrt, 1'b0);
    tick();
    checkOutput("done_wrt_c2", bus.wrt, 1'b1);
    checkOutput("done_ack", bus.tx_data, ACK);
    tick();
    checkOutput("done_wrt_c3", bus.wrt, 1'b0);
    checkOutput("done_one_wrt", wrt_cnt - wrt_base, 1);
    tick();

    applyStimulus(16'h7700, 16'h0001, "rd_drop_set");
    checkOutput("drop_cleared", cmd_drop, 1'b0);
    applyStimulus(16'h7700, 16'h0000, "rd_drop_clr");

    dump_base = dump_cnt;
    applyStimulus(16'h1300, NAK, "dump_ch3");
    checkOutput("dump_ch3_noreq", dump_cnt - dump_base, 0);
    applyStimulus(16'hF123, NAK, "op_f");
    applyStimulus(16'h0000, NAK, "op_0");
    applyStimulus(16'h7900, NAK, "rd_addr9");

    // A level held high must produce a single response.
    wrt_base     = wrt_cnt;
    bus.cmd_rcvd = 16'h7100;
    bus.cmd_rdy  = 1'b1;
    repeat (50) tick();
    bus.cmd_rdy = 1'b0;
    tick();
    checkOutput("held_one_rsp", wrt_cnt - wrt_base, 1);
    checkOutput("held_rsp_val", bus.tx_data, 16'h00C9);

    // Reset while waiting for a dump on channel 1.
    bus.cmd_rcvd = 16'h1100;
    bus.cmd_rdy  = 1'b1;
    tick();
    tick();
    bus.cmd_rdy = 1'b0;
    repeat (3) tick();
    checkOutput("pre_rst_ch", bus.dump_ch, 2'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx", bus.tx_data, 16'h0000);
    checkOutput("mid_rst_ch", bus.dump_ch, 2'd0);
    checkOutput("mid_rst_lvl", trig_lvl, 8'h80);
    checkOutput("mid_rst_pos", trig_pos, 9'h100);
    checkOutput("mid_rst_dec", decimator, 4'h0);
    checkOutput("mid_rst_cfg", trig_cfg, 6'h00);
    checkOutput("mid_rst_gain0", gain0, 3'h2);
    checkOutput("mid_rst_wrt", bus.wrt, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    wrt_base      = wrt_cnt;
    bus.dump_done = 1'b1;
    tick();
    bus.dump_done = 1'b0;
    repeat (5) tick();
    checkOutput("post_rst_no_wrt", wrt_cnt - wrt_base, 0);
    applyStimulus(16'h7100, 16'h0080, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
